alu_ctrl_fsm: RTL and testbench

ALU_CTRL_FSM -- requirements
Module: alu_ctrl_fsm

---
 rtl/alu_ctrl_fsm.sv | 271 +++++++++++++++++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// alu_ctrl_fsm
// Multi-cycle MIPS-style control unit implemented as a Moore FSM. Every output
// except pc_en is decoded from the registered state. The only exceptions are
// alu_control in EXEC and IEXEC, and the MEMADR/DECODE dispatch. These read the
// opcode/funct fields held in the instruction register. Those fields are read
// only in DECODE, MEMADR, EXEC and IEXEC.
//
// Parameter:
//   ILLEGAL_HALT  1: an unrecognised opcode/funct parks the FSM in HALT
//                 0: an unrecognised opcode/funct returns to FETCH (no-op)
// Optional feature macro:
//   ALU_CTRL_JAL_EN  when defined, opcode 000011 dispatches to the JAL state.
//                    Otherwise that opcode is illegal and state 14 is
//                    unreachable.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   opcode, funct        instruction fields [31:26] and [5:0]
//   zero                 ALU equality flag (qualifies pc_en in BRANCH)
//   alu_control          ALU op: 0000 and, 0001 or, 0010 add, 0011 lui, 0110 sub
//   alu_src_a            0 = PC, 1 = register A
//   alu_src_b            00 B, 01 const 4, 10 ext imm, 11 ext imm << 2
//   ext_op               1 = sign-extend immediate, 0 = zero-extend
//   pc_en, pc_src        PC load enable (pc_write | branch & zero), PC source
//   ir_write, i_or_d     instruction register load, memory address select
//   mem_read, mem_write  memory strobes
//   reg_write, reg_dst   register file write enable and destination select
//   mem_to_reg           register write data select
//   halted, state        HALT indicator and current state code for debug
// -----------------------------------------------------------------------------
module alu_ctrl_fsm #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13,
        S_JAL    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef ALU_CTRL_JAL_EN
    localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

    state_t state_r;
    state_t next_state_s;
    logic   pc_write_s;
    logic   branch_s;

    // Recognised R-type funct codes: add, addu, sub, subu, and, or.
    function automatic logic rtype_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001, 6'b100010,
            6'b100011, 6'b100100, 6'b100101: rtype_legal = 1'b1;
            default:                         rtype_legal = 1'b0;
        endcase
    endfunction

    // ALU operation for an R-type funct. Unsigned variants share the signed op.
    function automatic logic [3:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001: rtype_alu = 4'b0010;
            6'b100010, 6'b100011: rtype_alu = 4'b0110;
            6'b100100:            rtype_alu = 4'b0000;
            6'b100101:            rtype_alu = 4'b0001;
            default:              rtype_alu = 4'b0000;
        endcase
    endfunction

    // State register; reset forces RESET immediately, so all outputs clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; opcode/funct are only looked at in DECODE and MEMADR.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_RESET:  next_state_s = S_FETCH;
            S_FETCH:  next_state_s = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   next_state_s = S_MEMADR;
                    OP_ORI, OP_LUI: next_state_s = S_IEXEC;
                    OP_BEQ:         next_state_s = S_BRANCH;
                    OP_J:           next_state_s = S_JUMP;
`ifdef ALU_CTRL_JAL_EN
                    OP_JAL:         next_state_s = S_JAL;
`endif
                    OP_RTYPE: begin
                        if (rtype_legal(funct)) begin
                            next_state_s = S_EXEC;
                        end else if (ILLEGAL_HALT) begin
                            next_state_s = S_HALT;
                        end else begin
                            next_state_s = S_FETCH;
                        end
                    end
                    default: begin
                        if (ILLEGAL_HALT) begin
                            next_state_s = S_HALT;
                        end else begin
                            next_state_s = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_SW) begin
                    next_state_s = S_MEMWR;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMRD:  next_state_s = S_MEMWB;
            S_EXEC:   next_state_s = S_ALUWB;
            S_IEXEC:  next_state_s = S_IWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH,
            S_IWB, S_JUMP, S_JAL:
                      next_state_s = S_FETCH;
            S_HALT:   next_state_s = S_HALT;
            // The unused code 15 recovers through RESET.
            default:  next_state_s = S_RESET;
        endcase
    end

    // Moore output decode; everything not set for a state stays 0.
    always_comb begin
        alu_control = 4'b0000;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        ext_op      = 1'b0;
        pc_write_s  = 1'b0;
        branch_s    = 1'b0;
        pc_src      = 2'b00;
        ir_write    = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        halted      = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read    = 1'b1;
                ir_write    = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = 4'b0010;
                pc_write_s  = 1'b1;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_b   = 2'b11;
                ext_op      = 1'b1;
                alu_control = 4'b0010;
            end
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                ext_op      = 1'b1;
                alu_control = 4'b0010;
            end
            S_MEMRD: begin
                i_or_d      = 1'b1;
                mem_read    = 1'b1;
            end
            S_MEMWB: begin
                reg_write   = 1'b1;
                mem_to_reg  = 2'b01;
            end
            S_MEMWR: begin
                i_or_d      = 1'b1;
                mem_write   = 1'b1;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = rtype_alu(funct);
            end
            S_ALUWB: begin
                reg_write   = 1'b1;
                reg_dst     = 2'b01;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 4'b0110;
                branch_s    = 1'b1;
                pc_src      = 2'b01;
            end
            S_IEXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                if (opcode == OP_LUI) begin
                    alu_control = 4'b0011;
                end else begin
                    alu_control = 4'b0001;
                end
            end
            S_IWB: begin
                reg_write   = 1'b1;
            end
            S_JUMP: begin
                pc_write_s  = 1'b1;
                pc_src      = 2'b10;
            end
            S_JAL: begin
                pc_write_s  = 1'b1;
                pc_src      = 2'b10;
                reg_write   = 1'b1;
                reg_dst     = 2'b10;
                mem_to_reg  = 2'b10;
            end
            S_HALT: begin
                halted      = 1'b1;
            end
            default: begin
                halted      = 1'b0;
            end
        endcase
    end

    // A branch loads the PC in the same cycle that the ALU reports equality.
    assign pc_en = pc_write_s | (branch_s & zero);
    assign state = state_r;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
module tb_alu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;

    logic [3:0] alu_control, alu_control_nh;
    logic       alu_src_a, alu_src_a_nh;
    logic [1:0] alu_src_b, alu_src_b_nh;
    logic       ext_op, ext_op_nh;
    logic       pc_en, pc_en_nh;
    logic [1:0] pc_src, pc_src_nh;
    logic       ir_write, ir_write_nh;
    logic       i_or_d, i_or_d_nh;
    logic       mem_read, mem_read_nh;
    logic       mem_write, mem_write_nh;
    logic       reg_write, reg_write_nh;
    logic [1:0] reg_dst, reg_dst_nh;
    logic [1:0] mem_to_reg, mem_to_reg_nh;
    logic       halted, halted_nh;
    logic [3:0] state, state_nh;

    int n_checks = 0;
    int n_fail = 0;

    alu_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_op(ext_op), .pc_en(pc_en), .pc_src(pc_src), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .halted(halted), .state(state)
    );

    alu_ctrl_fsm #(.ILLEGAL_HALT(1'b0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_control(alu_control_nh), .alu_src_a(alu_src_a_nh), .alu_src_b(alu_src_b_nh),
        .ext_op(ext_op_nh), .pc_en(pc_en_nh), .pc_src(pc_src_nh), .ir_write(ir_write_nh),
        .i_or_d(i_or_d_nh), .mem_read(mem_read_nh), .mem_write(mem_write_nh),
        .reg_write(reg_write_nh), .reg_dst(reg_dst_nh), .mem_to_reg(mem_to_reg_nh),
        .halted(halted_nh), .state(state_nh)
    );

    // Packed view: pc_en,pc_src,ir_write,i_or_d,mem_read,mem_write,reg_write,
    //              reg_dst,mem_to_reg,alu_control,alu_src_a,alu_src_b,ext_op,halted
    logic [20:0] outs, outs_nh;
    assign outs    = {pc_en, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write,
                      reg_dst, mem_to_reg, alu_control, alu_src_a, alu_src_b, ext_op, halted};
    assign outs_nh = {pc_en_nh, pc_src_nh, ir_write_nh, i_or_d_nh, mem_read_nh, mem_write_nh,
                      reg_write_nh, reg_dst_nh, mem_to_reg_nh, alu_control_nh, alu_src_a_nh,
                      alu_src_b_nh, ext_op_nh, halted_nh};

    localparam logic [20:0] E_ZERO   = 21'd0;
    localparam logic [20:0] E_FETCH  = {1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0010, 1'b0, 2'b01, 1'b0, 1'b0};
    localparam logic [20:0] E_DECODE = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0010, 1'b0, 2'b11, 1'b1, 1'b0};
    localparam logic [20:0] E_MEMADR = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0010, 1'b1, 2'b10, 1'b1, 1'b0};
    localparam logic [20:0] E_MEMRD  = {1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] E_MEMWB  = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] E_MEMWR  = {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] E_ALUWB  = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] E_IWB    = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] E_BR_Z1  = {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0110, 1'b1, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] E_BR_Z0  = {1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0110, 1'b1, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] E_JUMP   = {1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] E_JAL    = {1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] E_HALT   = 21'd1;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset and return with both instances sitting in FETCH.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (state !== 4'd0 || outs !== E_ZERO) begin
            n_fail++;
            $display("FAIL reset_hold: state=%0d outs=%h expected state=0 outs=%h", state, outs, E_ZERO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release_noedge: state=%0d expected 0", state);
        end
        tick();
        n_checks++;
        if (state !== 4'd1 || outs !== E_FETCH || state_nh !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_first_edge: state=%0d nh=%0d outs=%h expected 1/1/%h", state, state_nh, outs, E_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [3:0]  st [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
        logic [20:0] ex [6] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        opcode = 6'b100011;
        funct  = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            // In MEMRD the opcode must be ignored.
            if (i == 3) opcode = 6'b111111;
            n_checks++;
            if (state !== st[i] || outs !== ex[i]) begin
                n_fail++;
                $display("FAIL lw cycle %0d: state=%0d outs=%h expected state=%0d outs=%h", i, state, outs, st[i], ex[i]);
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_sw();
        logic [3:0]  st [5] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd1};
        logic [20:0] ex [5] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
        opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (state !== st[i] || outs !== ex[i]) begin
                n_fail++;
                $display("FAIL sw cycle %0d: state=%0d outs=%h expected state=%0d outs=%h", i, state, outs, st[i], ex[i]);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn  [6] = '{6'b100010, 6'b100000, 6'b100011, 6'b100100, 6'b100101, 6'b100001};
        logic [3:0] alu [6] = '{4'b0110,   4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0010};
        logic [3:0]  st [5] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
        logic [20:0] ex [5];
        for (int k = 0; k < 6; k++) begin
            opcode = 6'b000000;
            funct  = fn[k];
            ex = '{E_FETCH, E_DECODE, {12'd0, alu[k], 1'b1, 2'b00, 1'b0, 1'b0}, E_ALUWB, E_FETCH};
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (state !== st[i] || outs !== ex[i]) begin
                    n_fail++;
                    $display("FAIL rtype funct=%b cycle %0d: state=%0d outs=%h expected state=%0d outs=%h", fn[k], i, state, outs, st[i], ex[i]);
                end
                if (i < 4) tick();
            end
        end
    endtask

    task automatic test_itype();
        logic [5:0] op  [2] = '{6'b001111, 6'b001101};
        logic [3:0] alu [2] = '{4'b0011,   4'b0001};
        logic [3:0]  st [5] = '{4'd1, 4'd2, 4'd10, 4'd11, 4'd1};
        logic [20:0] ex [5];
        for (int k = 0; k < 2; k++) begin
            opcode = op[k];
            ex = '{E_FETCH, E_DECODE, {12'd0, alu[k], 1'b1, 2'b10, 1'b0, 1'b0}, E_IWB, E_FETCH};
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (state !== st[i] || outs !== ex[i]) begin
                    n_fail++;
                    $display("FAIL itype op=%b cycle %0d: state=%0d outs=%h expected state=%0d outs=%h", op[k], i, state, outs, st[i], ex[i]);
                end
                if (i < 4) tick();
            end
        end
    endtask

    task automatic test_branch();
        logic [3:0]  st [4] = '{4'd1, 4'd2, 4'd9, 4'd1};
        logic [20:0] ex [4];
        for (int k = 0; k < 2; k++) begin
            opcode = 6'b000100;
            zero   = (k == 0) ? 1'b1 : 1'b0;
            ex = '{E_FETCH, E_DECODE, (k == 0) ? E_BR_Z1 : E_BR_Z0, E_FETCH};
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (state !== st[i] || outs !== ex[i]) begin
                    n_fail++;
                    $display("FAIL beq zero=%0d cycle %0d: state=%0d outs=%h expected state=%0d outs=%h", zero, i, state, outs, st[i], ex[i]);
                end
                if (i < 3) tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [3:0]  st [4] = '{4'd1, 4'd2, 4'd12, 4'd1};
        logic [20:0] ex [4] = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
        opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (state !== st[i] || outs !== ex[i]) begin
                n_fail++;
                $display("FAIL jump cycle %0d: state=%0d outs=%h expected state=%0d outs=%h", i, state, outs, st[i], ex[i]);
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_illegal();
        logic [5:0] op [2] = '{6'b111111, 6'b000000};
        logic [5:0] fn [2] = '{6'b000000, 6'b101010};
        for (int k = 0; k < 2; k++) begin
            opcode = op[k];
            funct  = fn[k];
            tick();
            tick();
            n_checks++;
            if (state !== 4'd13 || outs !== E_HALT) begin
                n_fail++;
                $display("FAIL illegal_halt op=%b fn=%b: state=%0d outs=%h expected state=13 outs=%h", op[k], fn[k], state, outs, E_HALT);
            end
            n_checks++;
            if (state_nh !== 4'd1 || outs_nh !== E_FETCH) begin
                n_fail++;
                $display("FAIL illegal_nohalt op=%b fn=%b: state=%0d outs=%h expected state=1 outs=%h", op[k], fn[k], state_nh, outs_nh, E_FETCH);
            end
            // A legal opcode must not release HALT.
            opcode = 6'b100011;
            tick();
            tick();
            tick();
            n_checks++;
            if (state !== 4'd13 || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_sticky: state=%0d halted=%0d expected 13/1", state, halted);
            end
            do_reset();
            n_checks++;
            if (state !== 4'd1) begin
                n_fail++;
                $display("FAIL halt_exit_reset: state=%0d expected 1", state);
            end
        end
    endtask

    task automatic test_jal();
        opcode = 6'b000011;
        tick();
        tick();
`ifdef ALU_CTRL_JAL_EN
        n_checks++;
        if (state !== 4'd14 || outs !== E_JAL) begin
            n_fail++;
            $display("FAIL jal: state=%0d outs=%h expected state=14 outs=%h", state, outs, E_JAL);
        end
        tick();
        n_checks++;
        if (state !== 4'd1) begin
            n_fail++;
            $display("FAIL jal_return: state=%0d expected 1", state);
        end
`else
        n_checks++;
        if (state !== 4'd13 || outs !== E_HALT) begin
            n_fail++;
            $display("FAIL jal_disabled: state=%0d outs=%h expected state=13 outs=%h", state, outs, E_HALT);
        end
`endif
        do_reset();
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011;
        tick();
        tick();
        tick();
        n_checks++;
        if (state !== 4'd4) begin
            n_fail++;
            $display("FAIL midreset_setup: state=%0d expected 4", state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'd0 || outs !== E_ZERO) begin
            n_fail++;
            $display("FAIL midreset_async: state=%0d outs=%h expected state=0 outs=%h", state, outs, E_ZERO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (state !== 4'd1 || outs !== E_FETCH) begin
            n_fail++;
            $display("FAIL midreset_release: state=%0d outs=%h expected state=1 outs=%h", state, outs, E_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_itype();
        test_branch();
        test_jump();
        test_illegal();
        test_jal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
